huffman_stream_decoder: RTL and testbench

Sequential, multi-table successor to the combinational single-lookup Huffman decoder. Consumes an MSB-first entropy-coded byte stream and holds a bit buffer. Decodes one Huffman symbol plus its VLI magnitude bits per cycle using one of NUM_TABLES run-time-loadable tables. Emits (run, vli_size, signed value) tokens to the downstream dequant/zig-zag stage over a valid/ready handshake.

---
 rtl/huffman_stream_decoder.sv | 227 ++++++++++++++++++++++
 tb/tb_huffman_stream_decoder.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_stream_decoder.sv
// Purpose: Huffman + VLI token decoder for an MSB-first entropy-coded byte stream, with NUM_TABLES loadable tables.
// Latency: one cycle from a decodable symbol in the bit buffer to out_valid; one token per cycle sustained.
// Backpressure: out_valid && !out_ready freezes the token and the buffer; byte intake continues while space remains.
//
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   in_valid/in_ready     : byte intake handshake; in_byte is consumed MSB first, in_last marks the final scan byte
//   tbl_sel               : table used for decoding (sampled only when a decode fires)
//   tbl_wr_*              : table entry write port (code MSB-aligned, size 0 = invalid, symbol = {run, vli_size})
//   out_valid/out_ready   : token handshake; run, vli_size, value (EXTENDed), code_size
//   done                  : one-cycle pulse when a finished scan has fully drained
//   error                 : sticky flag for undecodable bits
module huffman_stream_decoder #(
  parameter int H          = 16,
  parameter int NUM_TABLES = 4,
  parameter int BUF_W      = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [7:0]                    in_byte,
  input  logic                          in_last,
  input  logic [$clog2(NUM_TABLES)-1:0] tbl_sel,
  input  logic                          tbl_wr_en,
  input  logic [$clog2(NUM_TABLES)-1:0] tbl_wr_sel,
  input  logic [$clog2(H)-1:0]          tbl_wr_idx,
  input  logic [15:0]                   tbl_wr_code,
  input  logic [4:0]                    tbl_wr_size,
  input  logic [7:0]                    tbl_wr_symbol,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [3:0]                    run,
  output logic [3:0]                    vli_size,
  output logic [15:0]                   value,
  output logic [4:0]                    code_size,
  output logic                          done,
  output logic                          error
);

  localparam int IW = $clog2(H);
  localparam int CW = $clog2(BUF_W + 1);

  // Table storage
  logic [15:0] tcode_q [NUM_TABLES][H];
  logic [15:0] tcode_d [NUM_TABLES][H];
  logic [4:0]  tsize_q [NUM_TABLES][H];
  logic [4:0]  tsize_d [NUM_TABLES][H];
  logic [7:0]  tsym_q  [NUM_TABLES][H];
  logic [7:0]  tsym_d  [NUM_TABLES][H];

  // Bit buffer: valid bits are MSB-aligned, bits below the count are kept zero
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_seen_q, last_seen_d;
  logic             error_q, error_d;
  logic             done_q, done_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       run_q, run_d;
  logic [3:0]       vli_q, vli_d;
  logic [15:0]      value_q, value_d;
  logic [4:0]       code_size_q, code_size_d;

  // Decode datapath
  logic [15:0]      top16;
  logic [H-1:0]     match_vec;
  logic             hit;
  logic [IW-1:0]    hit_idx;
  logic [4:0]       hit_size;
  logic [7:0]       hit_sym;
  logic [3:0]       hit_vli;
  logic [CW-1:0]    need;
  logic             avail;
  logic             fire;
  logic             err_trig;
  logic             done_cond;
  logic             take;
  logic [15:0]      vli_bits;
  logic             vli_msb;
  logic [15:0]      value_ext;
  logic [CW-1:0]    consumed;
  logic [CW-1:0]    cnt_after;
  logic [BUF_W-1:0] byte_ext;

  assign top16 = buf_q[BUF_W-1 -: 16];

  // An entry matches when it is valid, fully covered by buffered bits, and its
  // top size bits agree with the buffer head.
  always_comb begin
    for (int i = 0; i < H; i++) begin
      match_vec[i] = (tsize_q[tbl_sel][i] != 5'd0) &&
                     (CW'(tsize_q[tbl_sel][i]) <= cnt_q) &&
                     (((top16 ^ tcode_q[tbl_sel][i]) & ~(16'hFFFF >> tsize_q[tbl_sel][i])) == 16'd0);
    end
  end

  // Lowest matching index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = H - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign hit_size = tsize_q[tbl_sel][hit_idx];
  assign hit_sym  = tsym_q[tbl_sel][hit_idx];
  assign hit_vli  = hit_sym[3:0];
  assign need     = CW'(hit_size) + CW'(hit_vli);
  assign avail    = hit && (cnt_q >= need);
  assign fire     = avail && !error_q && (!out_valid_q || out_ready);
  // Sixteen bits cover the longest code, so no match at that depth can never resolve.
  assign err_trig = (cnt_q >= CW'(16)) && !hit;
  assign done_cond = last_seen_q && !avail && !out_valid_q && !error_q && !err_trig;

  assign in_ready = !error_q && !last_seen_q && (cnt_q <= CW'(BUF_W - 8));
  assign take     = in_valid && in_ready;

  // Magnitude bits sit right after the code; a shift by BUF_W yields zero for vli_size = 0.
  assign vli_bits  = 16'((buf_q << hit_size) >> (CW'(BUF_W) - CW'(hit_vli)));
  assign vli_msb   = |(vli_bits & (16'd1 << (hit_vli - 4'd1)));
  assign value_ext = (hit_vli == 4'd0) ? 16'd0 :
                     vli_msb ? vli_bits :
                     (vli_bits - ((16'd1 << hit_vli) - 16'd1));

  assign byte_ext = {in_byte, {(BUF_W-8){1'b0}}} >> cnt_after;

  // Table writes land the cycle after the strobe, so an in-flight decode sees old contents.
  always_comb begin
    tcode_d = tcode_q;
    tsize_d = tsize_q;
    tsym_d  = tsym_q;
    if (tbl_wr_en) begin
      tcode_d[tbl_wr_sel][tbl_wr_idx] = tbl_wr_code;
      tsize_d[tbl_wr_sel][tbl_wr_idx] = tbl_wr_size;
      tsym_d[tbl_wr_sel][tbl_wr_idx]  = tbl_wr_symbol;
    end
  end

  always_comb begin
    consumed    = fire ? need : '0;
    cnt_after   = cnt_q - consumed;
    // Shift out the consumed bits and append the new byte just below what remains.
    buf_d       = buf_q << consumed;
    cnt_d       = cnt_after;
    last_seen_d = last_seen_q;
    error_d     = error_q | err_trig;
    done_d      = 1'b0;
    out_valid_d = out_valid_q && !out_ready;
    run_d       = run_q;
    vli_d       = vli_q;
    value_d     = value_q;
    code_size_d = code_size_q;

    if (take) begin
      buf_d = buf_d | byte_ext;
      cnt_d = cnt_after + CW'(8);
      if (in_last) last_seen_d = 1'b1;
    end

    if (fire) begin
      out_valid_d = 1'b1;
      run_d       = hit_sym[7:4];
      vli_d       = hit_vli;
      value_d     = value_ext;
      code_size_d = hit_size;
    end

    // Scan drained: drop the padding bits and rearm for the next scan.
    if (done_cond) begin
      done_d      = 1'b1;
      buf_d       = '0;
      cnt_d       = '0;
      last_seen_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int t = 0; t < NUM_TABLES; t++) begin
        for (int i = 0; i < H; i++) begin
          tsize_q[t][i] <= 5'd0;
        end
      end
      buf_q       <= '0;
      cnt_q       <= '0;
      last_seen_q <= 1'b0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      run_q       <= 4'd0;
      vli_q       <= 4'd0;
      value_q     <= 16'd0;
      code_size_q <= 5'd0;
    end else begin
      tsize_q     <= tsize_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      last_seen_q <= last_seen_d;
      error_q     <= error_d;
      done_q      <= done_d;
      out_valid_q <= out_valid_d;
      run_q       <= run_d;
      vli_q       <= vli_d;
      value_q     <= value_d;
      code_size_q <= code_size_d;
    end
  end

  // Codes and symbols are only meaningful behind a nonzero size, so they need no reset.
  always_ff @(posedge clock) begin
    tcode_q <= tcode_d;
    tsym_q  <= tsym_d;
  end

  assign out_valid = out_valid_q;
  assign run       = run_q;
  assign vli_size  = vli_q;
  assign value     = value_q;
  assign code_size = code_size_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_huffman_stream_decoder.sv
module tb_huffman_stream_decoder;

  logic        clock = 1'b0;
  logic        reset, in_valid, in_last, out_ready, tbl_wr_en;
  logic [7:0]  in_byte, tbl_wr_symbol;
  logic [1:0]  tbl_sel, tbl_wr_sel;
  logic [3:0]  tbl_wr_idx;
  logic [15:0] tbl_wr_code;
  logic [4:0]  tbl_wr_size;
  logic        in_ready, out_valid, done, error;
  logic [3:0]  run, vli_size;
  logic [15:0] value;
  logic [4:0]  code_size;

  huffman_stream_decoder #(.H(16), .NUM_TABLES(4), .BUF_W(32)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
    .tbl_sel(tbl_sel), .tbl_wr_en(tbl_wr_en), .tbl_wr_sel(tbl_wr_sel), .tbl_wr_idx(tbl_wr_idx),
    .tbl_wr_code(tbl_wr_code), .tbl_wr_size(tbl_wr_size), .tbl_wr_symbol(tbl_wr_symbol),
    .out_valid(out_valid), .out_ready(out_ready), .run(run), .vli_size(vli_size),
    .value(value), .code_size(code_size), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  r;
    logic [3:0]  v;
    logic [15:0] val;
    logic [4:0]  cs;
    logic [31:0] cyc;
  } tok_t;

  int checks = 0;
  int errors = 0;

  // Shadow of the table contents, used by the reference model
  logic [15:0] m_code [4][16];
  logic [4:0]  m_size [4][16];
  logic [7:0]  m_sym  [4][16];

  logic [7:0] sbytes[$];
  bit         slast;
  tok_t       got[$];
  tok_t       exp[$];
  int         done_cnt, in_stalls, hold_n, hold_diff;

  logic [15:0] rc [11];
  int          rs [11];

  task automatic model_clear();
    for (int t = 0; t < 4; t++)
      for (int i = 0; i < 16; i++) begin
        m_code[t][i] = '0; m_size[t][i] = '0; m_sym[t][i] = '0;
      end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; tbl_wr_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic load_entry(input int t, input int i, input logic [15:0] c,
                            input logic [4:0] s, input logic [7:0] y);
    @(negedge clock);
    tbl_wr_en = 1'b1; tbl_wr_sel = t[1:0]; tbl_wr_idx = i[3:0];
    tbl_wr_code = c; tbl_wr_size = s; tbl_wr_symbol = y;
    m_code[t][i] = c; m_size[t][i] = s; m_sym[t][i] = y;
    @(negedge clock);
    tbl_wr_en = 1'b0;
  endtask

  task automatic load_basic_t0();
    load_entry(0, 0, 16'h0000, 5'd2, 8'h00);
    load_entry(0, 1, 16'h4000, 5'd3, 8'h01);
    load_entry(0, 2, 16'h6000, 5'd3, 8'h02);
  endtask

  // Reference model: decode the whole byte list as a bit queue using the
  // lowest-index-match rule and JPEG EXTEND on the magnitude bits.
  task automatic model_run(input int sel, output bit m_err);
    bit bits[$];
    bit going;
    exp.delete();
    foreach (sbytes[k]) for (int j = 7; j >= 0; j--) bits.push_back(sbytes[k][j]);
    m_err = 0;
    going = 1;
    while (going) begin
      int rem, hitx, s, v, b, val;
      tok_t t;
      rem = bits.size();
      hitx = -1;
      for (int i = 0; i < 16; i++) begin
        if (hitx < 0 && m_size[sel][i] != 0 && int'(m_size[sel][i]) <= rem) begin
          bit ok;
          ok = 1;
          for (int j = 0; j < int'(m_size[sel][i]); j++)
            if (bits[j] != m_code[sel][i][15-j]) ok = 0;
          if (ok) hitx = i;
        end
      end
      if (hitx < 0) begin
        if (rem >= 16) m_err = 1;
        going = 0;
      end else begin
        s = int'(m_size[sel][hitx]);
        v = int'(m_sym[sel][hitx][3:0]);
        if (rem < s + v) going = 0;
        else begin
          b = 0;
          for (int j = 0; j < v; j++) b = b * 2 + int'(bits[s+j]);
          if (v == 0) val = 0;
          else if (b >= (1 << (v - 1))) val = b;
          else val = b - (1 << v) + 1;
          t.r = m_sym[sel][hitx][7:4]; t.v = v[3:0]; t.val = val[15:0]; t.cs = s[4:0]; t.cyc = 0;
          exp.push_back(t);
          for (int j = 0; j < s + v; j++) void'(bits.pop_front());
        end
      end
    end
  endtask

  // Drives sbytes and collects tokens; inputs change on the falling edge and the
  // handshakes that the next rising edge will see are recorded here.
  task automatic run_stream(input int max_cyc, input int vpct, input int rpct, input int hold);
    int ptr, held, cyc, post;
    tok_t cur, snap;
    ptr = 0; held = 0; cyc = 0; post = 0; snap = '0;
    got.delete(); done_cnt = 0; in_stalls = 0; hold_n = 0; hold_diff = 0;
    while (cyc < max_cyc && post < 5) begin
      @(negedge clock);
      cyc++;
      if (done) done_cnt++;
      if (done_cnt > 0) post++;
      cur.r = run; cur.v = vli_size; cur.val = value; cur.cs = code_size; cur.cyc = cyc;
      if (ptr < sbytes.size() && $urandom_range(99) < vpct) begin
        in_valid = 1'b1; in_byte = sbytes[ptr]; in_last = slast && (ptr == sbytes.size() - 1);
      end else begin
        in_valid = 1'b0; in_last = 1'b0;
      end
      if (out_valid && held < hold) begin
        out_ready = 1'b0;
        if (held == 0) snap = cur;
        else if (cur[60:32] !== snap[60:32]) hold_diff++;
        hold_n++;
        held++;
      end else begin
        out_ready = ($urandom_range(99) < rpct);
      end
      if (in_valid && !in_ready) in_stalls++;
      if (in_valid && in_ready) ptr++;
      if (out_valid && out_ready) got.push_back(cur);
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if ({run, vli_size, value, code_size} !== 29'd0) begin
      errors++; $display("FAIL reset_token: got %h want 0", {run, vli_size, value, code_size});
    end
  endtask

  task automatic test_basic();
    tok_t want [3];
    want[0] = {4'd0, 4'd1, 16'h0001, 5'd3, 32'd0};
    want[1] = {4'd0, 4'd2, 16'hFFFD, 5'd3, 32'd0};
    want[2] = {4'd0, 4'd2, 16'h0003, 5'd3, 32'd0};
    load_basic_t0();
    tbl_sel = 2'd0;
    sbytes = '{8'h56, 8'h3F}; slast = 1;
    run_stream(200, 100, 100, 0);
    checks++; if (got.size() != 3) begin errors++; $display("FAIL basic_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i][60:32] !== want[i][60:32]) begin
        errors++; $display("FAIL basic_tok%0d: got %h want %h", i, got[i][60:32], want[i][60:32]);
      end
    end
    // Tokens 2 and 3 are both decodable once the second byte lands: back-to-back.
    if (got.size() == 3) begin
      checks++;
      if (got[2].cyc - got[1].cyc != 1) begin
        errors++; $display("FAIL back_to_back: got gap %0d want 1", got[2].cyc - got[1].cyc);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: got %0d want 1", done_cnt); end
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL basic_error: got %b want 0", error); end
  endtask

  task automatic test_backpressure();
    tok_t want [3];
    want[0] = {4'd0, 4'd1, 16'h0001, 5'd3, 32'd0};
    want[1] = {4'd0, 4'd2, 16'hFFFD, 5'd3, 32'd0};
    want[2] = {4'd0, 4'd2, 16'h0003, 5'd3, 32'd0};
    tbl_sel = 2'd0;
    sbytes = '{8'h56, 8'h3F}; slast = 1;
    run_stream(200, 100, 100, 5);
    checks++; if (hold_n != 5) begin errors++; $display("FAIL bp_hold_cycles: got %0d want 5", hold_n); end
    checks++; if (hold_diff != 0) begin errors++; $display("FAIL bp_hold_stable: got %0d changes want 0", hold_diff); end
    checks++; if (in_stalls != 0) begin errors++; $display("FAIL bp_in_ready: got %0d stalls want 0", in_stalls); end
    checks++; if (got.size() != 3) begin errors++; $display("FAIL bp_count: got %0d want 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      checks++;
      if (got[i][60:32] !== want[i][60:32]) begin
        errors++; $display("FAIL bp_tok%0d: got %h want %h", i, got[i][60:32], want[i][60:32]);
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_zrl();
    load_entry(1, 0, 16'hFFFE, 5'd16, 8'hF0);
    tbl_sel = 2'd1;
    sbytes = '{8'hFF, 8'hFE}; slast = 1;
    run_stream(200, 100, 100, 0);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL zrl_count: got %0d want 1", got.size()); end
    else begin
      checks++;
      if (got[0][60:32] !== {4'd15, 4'd0, 16'd0, 5'd16}) begin
        errors++; $display("FAIL zrl_tok: got %h want %h", got[0][60:32], {4'd15, 4'd0, 16'd0, 5'd16});
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL zrl_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_dup();
    load_entry(3, 0, 16'h4000, 5'd3, 8'h01);
    load_entry(3, 3, 16'h4000, 5'd3, 8'h05);
    tbl_sel = 2'd3;
    sbytes = '{8'h5F}; slast = 1;
    run_stream(200, 100, 100, 0);
    checks++; if (got.size() != 1) begin errors++; $display("FAIL dup_count: got %0d want 1", got.size()); end
    else begin
      checks++;
      if (got[0][60:32] !== {4'd0, 4'd1, 16'd1, 5'd3}) begin
        errors++; $display("FAIL dup_tok: got %h want %h", got[0][60:32], {4'd0, 4'd1, 16'd1, 5'd3});
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL dup_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 4; it++) begin
      bit bits[$];
      bit merr;
      int off, nt;
      off = $urandom_range(15);
      for (int i = 0; i < 16; i++) load_entry(2, i, 16'h0, 5'd0, 8'h0);
      for (int k = 0; k < 11; k++)
        load_entry(2, (k + off) % 16, rc[k], rs[k][4:0], 8'($urandom_range(255)));
      tbl_sel = 2'd2;
      nt = $urandom_range(20, 5);
      for (int n = 0; n < nt; n++) begin
        int k, v;
        k = $urandom_range(10);
        v = int'(m_sym[2][(k + off) % 16][3:0]);
        for (int j = 0; j < rs[k]; j++) bits.push_back(rc[k][15-j]);
        for (int j = 0; j < v; j++) bits.push_back(1'($urandom_range(1)));
      end
      while (bits.size() % 8 != 0) bits.push_back(1'b1);
      sbytes.delete();
      for (int b = 0; b < bits.size() / 8; b++) begin
        logic [7:0] byt;
        for (int j = 0; j < 8; j++) byt[7-j] = bits[b*8 + j];
        sbytes.push_back(byt);
      end
      slast = 1;
      model_run(2, merr);
      run_stream(3000, 70, 60, 0);
      checks++;
      if (got.size() != exp.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d want %0d", it, got.size(), exp.size());
      end
      for (int i = 0; i < got.size() && i < exp.size(); i++) begin
        checks++;
        if (got[i][60:32] !== exp[i][60:32]) begin
          errors++; $display("FAIL rand%0d_tok%0d: got %h want %h", it, i, got[i][60:32], exp[i][60:32]);
        end
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL rand%0d_done: got %0d want 1", it, done_cnt); end
      checks++; if (error !== merr) begin errors++; $display("FAIL rand%0d_error: got %b want %b", it, error, merr); end
    end
  endtask

  task automatic test_error();
    bit merr;
    tbl_sel = 2'd0;
    sbytes = '{8'hFF, 8'hFF}; slast = 0;
    model_run(0, merr);
    run_stream(20, 100, 100, 0);
    checks++; if (error !== merr) begin errors++; $display("FAIL err_flag: got %b want %b", error, merr); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL err_in_ready: got %b want 0", in_ready); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL err_tokens: got %0d want 0", got.size()); end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL err_done: got %0d want 0", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit merr;
    do_reset();
    load_basic_t0();
    tbl_sel = 2'd0;
    sbytes = '{8'h56, 8'h3F}; slast = 0;
    run_stream(6, 100, 0, 0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending: got %b want 1", out_valid); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_clear();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b want 1", in_ready); end
    sbytes = '{8'h56, 8'h3F}; slast = 0;
    model_run(0, merr);
    run_stream(20, 100, 100, 0);
    checks++; if (error !== merr) begin errors++; $display("FAIL mid_error: got %b want %b", error, merr); end
    checks++; if (got.size() != 0) begin errors++; $display("FAIL mid_tokens: got %0d want 0", got.size()); end
  endtask

  initial begin
    rc = '{16'h0000, 16'h4000, 16'h6000, 16'h8000, 16'hA000, 16'hC000,
           16'hE000, 16'hF000, 16'hF800, 16'hFC00, 16'hFE00};
    rs = '{2, 3, 3, 3, 3, 3, 4, 5, 6, 7, 8};
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h0; out_ready = 1'b0;
    tbl_sel = 2'd0; tbl_wr_en = 1'b0; tbl_wr_sel = 2'd0; tbl_wr_idx = 4'd0;
    tbl_wr_code = 16'h0; tbl_wr_size = 5'd0; tbl_wr_symbol = 8'h0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zrl();
    test_dup();
    test_random();
    test_error();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
